// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch controller.
// Decides each cycle whether the PC block runs normally, redirects to a branch
// target, or is blocked by an icache miss or a downstream hazard. A branch that
// lands on a blocked cycle is parked (oldest wins) and replayed on the first
// unblocked cycle. A sticky timeout flags icache misses that last too long.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid_i,
  input  logic [63:0] branch_target_i,
  input  logic        stall_req_i,
  input  logic        icache_req_valid_i,
  input  logic        icache_resp_valid_i,
  output logic [1:0]  ctrl_signal_o,
  output logic [63:0] pc_new_o,
  output logic        flush_o,
  output logic        timeout_o
);

  localparam logic [1:0] CTRL_DEFAULT = 2'b00;
  localparam logic [1:0] CTRL_BRANCH  = 2'b01;
  localparam logic [1:0] CTRL_BLOCK   = 2'b10;

  // Miss counter is 8 bits wide and saturates, so the limit is clamped to it.
  localparam logic [7:0] TIMEOUT_CNT = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    MISS = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic        pending_r, pending_s;
  logic [63:0] pending_tgt_r, pending_tgt_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        timeout_r, timeout_s;
  logic [1:0]  ctrl_s;
  logic [63:0] pc_s;
  logic        miss_s;
  logic        park_s;

  // Next-state, parking and control-code decision for the current cycle.
  always_comb begin
    state_s       = state_r;
    pending_s     = pending_r;
    pending_tgt_s = pending_tgt_r;
    cnt_s         = cnt_r;
    timeout_s     = timeout_r;
    ctrl_s        = CTRL_DEFAULT;
    pc_s          = 64'd0;
    miss_s        = icache_req_valid_i & ~icache_resp_valid_i;
    // Only the oldest branch is kept; later ones are dropped while one waits.
    park_s        = branch_valid_i & ~pending_r;

    case (state_r)
      RUN: begin
        if (pending_r) begin
          // Replay the parked branch before anything else; a miss or stall
          // seen now is simply re-evaluated next cycle.
          ctrl_s        = CTRL_BRANCH;
          pc_s          = pending_tgt_r;
          pending_s     = 1'b0;
          pending_tgt_s = 64'd0;
        end else if (miss_s) begin
          ctrl_s  = CTRL_BLOCK;
          state_s = MISS;
          cnt_s   = 8'd0;
          if (park_s) begin
            pending_s     = 1'b1;
            pending_tgt_s = branch_target_i;
          end else begin
            pending_s     = pending_r;
          end
        end else if (stall_req_i) begin
          ctrl_s  = CTRL_BLOCK;
          state_s = HOLD;
          if (park_s) begin
            pending_s     = 1'b1;
            pending_tgt_s = branch_target_i;
          end else begin
            pending_s     = pending_r;
          end
        end else if (branch_valid_i) begin
          ctrl_s = CTRL_BRANCH;
          pc_s   = branch_target_i;
        end else begin
          ctrl_s = CTRL_DEFAULT;
        end
      end

      MISS: begin
        ctrl_s = CTRL_BLOCK;
        if (park_s) begin
          pending_s     = 1'b1;
          pending_tgt_s = branch_target_i;
        end else begin
          pending_s     = pending_r;
        end
        cnt_s = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);
        if (cnt_s >= TIMEOUT_CNT) begin
          timeout_s = 1'b1;
        end else begin
          timeout_s = timeout_r;
        end
        if (icache_resp_valid_i) begin
          state_s = stall_req_i ? HOLD : RUN;
        end else begin
          state_s = MISS;
        end
      end

      HOLD: begin
        ctrl_s = CTRL_BLOCK;
        if (park_s) begin
          pending_s     = 1'b1;
          pending_tgt_s = branch_target_i;
        end else begin
          pending_s     = pending_r;
        end
        if (!stall_req_i) begin
          state_s = RUN;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s       = RUN;
        pending_s     = 1'b0;
        pending_tgt_s = 64'd0;
        cnt_s         = 8'd0;
      end
    endcase
  end

  // State, parked branch, miss counter and sticky timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      pending_r     <= 1'b0;
      pending_tgt_r <= 64'd0;
      cnt_r         <= 8'd0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pending_r     <= pending_s;
      pending_tgt_r <= pending_tgt_s;
      cnt_r         <= cnt_s;
      timeout_r     <= timeout_s;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  always_comb begin
    if (rst) begin
      ctrl_signal_o = CTRL_DEFAULT;
      pc_new_o      = 64'd0;
      flush_o       = 1'b0;
    end else begin
      ctrl_signal_o = ctrl_s;
      pc_new_o      = pc_s;
      flush_o       = (ctrl_s == CTRL_BRANCH);
    end
  end

  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic, checked against a
// behavioural model that tracks "blocked by icache", "blocked by hazard", a
// queue of parked branches and a miss-cycle count.
module tb_fetch_ctrl;

  localparam logic [1:0] C_DEF = 2'b00;
  localparam logic [1:0] C_BR  = 2'b01;
  localparam logic [1:0] C_BLK = 2'b10;
  localparam int LIMIT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_valid_i = 1'b0;
  logic [63:0] branch_target_i = 64'd0;
  logic        stall_req_i = 1'b0;
  logic        icache_req_valid_i = 1'b0;
  logic        icache_resp_valid_i = 1'b0;
  logic [1:0]  ctrl_signal_o;
  logic [63:0] pc_new_o;
  logic        flush_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit          m_miss;
  bit          m_hold;
  int          m_miss_cycles;
  bit          m_tmo;
  logic [63:0] m_pend[$];

  logic [1:0]  last_ctrl;
  logic [63:0] last_pc;

  fetch_ctrl #(.TIMEOUT(LIMIT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch_valid_i      (branch_valid_i),
    .branch_target_i     (branch_target_i),
    .stall_req_i         (stall_req_i),
    .icache_req_valid_i  (icache_req_valid_i),
    .icache_resp_valid_i (icache_resp_valid_i),
    .ctrl_signal_o       (ctrl_signal_o),
    .pc_new_o            (pc_new_o),
    .flush_o             (flush_o),
    .timeout_o           (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_miss = 1'b0;
    m_hold = 1'b0;
    m_miss_cycles = 0;
    m_tmo = 1'b0;
    m_pend.delete();
  endtask

  // One clock cycle: drive at negedge, check before the next posedge, then
  // advance the model to what the coming edge should produce.
  task automatic do_cycle(input bit bv, input logic [63:0] tgt, input bit st,
                          input bit rq, input bit rs);
    logic [1:0]  e_ctrl;
    logic [63:0] e_pc;
    @(negedge clk);
    branch_valid_i      = bv;
    branch_target_i     = tgt;
    stall_req_i         = st;
    icache_req_valid_i  = rq;
    icache_resp_valid_i = rs;
    #1;
    e_pc = 64'd0;
    check_eq("timeout", {63'd0, timeout_o}, {63'd0, m_tmo});
    if (!m_miss && !m_hold) begin
      if (m_pend.size() > 0) begin
        e_ctrl = C_BR;
        e_pc   = m_pend.pop_front();
      end else if (rq && !rs) begin
        e_ctrl = C_BLK;
        if (bv) m_pend.push_back(tgt);
        m_miss = 1'b1;
        m_miss_cycles = 0;
      end else if (st) begin
        e_ctrl = C_BLK;
        if (bv) m_pend.push_back(tgt);
        m_hold = 1'b1;
      end else if (bv) begin
        e_ctrl = C_BR;
        e_pc   = tgt;
      end else begin
        e_ctrl = C_DEF;
      end
    end else begin
      e_ctrl = C_BLK;
      if (bv && m_pend.size() == 0) m_pend.push_back(tgt);
      if (m_miss) begin
        m_miss_cycles++;
        if (m_miss_cycles >= LIMIT) m_tmo = 1'b1;
        if (rs) begin
          m_miss = 1'b0;
          m_hold = st;
        end
      end else begin
        if (!st) m_hold = 1'b0;
      end
    end
    check_eq("ctrl", {62'd0, ctrl_signal_o}, {62'd0, e_ctrl});
    check_eq("pc_new", pc_new_o, e_pc);
    check_eq("flush", {63'd0, flush_o}, {63'd0, (e_ctrl == C_BR)});
    last_ctrl = ctrl_signal_o;
    last_pc   = pc_new_o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between clock edges, check outputs at once, release at a negedge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    branch_valid_i     = 1'b1;
    branch_target_i    = 64'hDEAD_BEEF;
    icache_req_valid_i = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rst_ctrl", {62'd0, ctrl_signal_o}, {62'd0, C_DEF});
    check_eq("rst_pc", pc_new_o, 64'd0);
    check_eq("rst_flush", {63'd0, flush_o}, 64'd0);
    check_eq("rst_timeout", {63'd0, timeout_o}, 64'd0);
    @(negedge clk);
    branch_valid_i      = 1'b0;
    branch_target_i     = 64'd0;
    stall_req_i         = 1'b0;
    icache_req_valid_i  = 1'b0;
    icache_resp_valid_i = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    last_ctrl = C_DEF;
    last_pc   = 64'd0;
    // reset held with live inputs: outputs must stay quiet
    branch_valid_i  = 1'b1;
    branch_target_i = 64'h1234;
    #3;
    check_eq("init_ctrl", {62'd0, ctrl_signal_o}, {62'd0, C_DEF});
    check_eq("init_pc", pc_new_o, 64'd0);
    check_eq("init_flush", {63'd0, flush_o}, 64'd0);
    check_eq("init_timeout", {63'd0, timeout_o}, 64'd0);
    async_reset();

    // straight-line fetch
    idle(10);

    // branch in RUN
    do_cycle(1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
    check_eq("br_run_pc", last_pc, 64'h8000_0100);
    idle(1);
    check_eq("br_run_after", {62'd0, last_ctrl}, {62'd0, C_DEF});

    // miss with branch parked on cycle 2, response on cycle 6
    for (int c = 1; c <= 5; c++)
      do_cycle(c == 2, (c == 2) ? 64'h8000_0200 : 64'd0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    check_eq("miss_exit_blk", {62'd0, last_ctrl}, {62'd0, C_BLK});
    do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    check_eq("miss_replay_pc", last_pc, 64'h8000_0200);
    idle(2);

    // two branches during HOLD: only the first survives
    do_cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 64'h10, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 64'h20, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_replay_pc", last_pc, 64'h10);
    idle(3);

    // replay wins over a new miss the same cycle
    do_cycle(1'b1, 64'h44, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 64'h55, 1'b0, 1'b1, 1'b0);
    check_eq("prio_replay_pc", last_pc, 64'h44);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // long miss drives timeout, which then sticks
    for (int c = 0; c < 300; c++) do_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    check_eq("tmo_set", {63'd0, timeout_o}, 64'd1);
    do_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    idle(5);
    check_eq("tmo_sticky", {63'd0, timeout_o}, 64'd1);

    // reset mid-miss with a parked branch
    do_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 64'h77, 1'b0, 1'b1, 1'b0);
    async_reset();
    idle(4);
    check_eq("post_rst_ctrl", {62'd0, last_ctrl}, {62'd0, C_DEF});

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        do_cycle(($urandom % 4) == 0, {$urandom, $urandom},
                 ($urandom % 5) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: branch_valid_i  input  1  execute stage requests redirect this cycle.
REQ-004 SHALL have port: branch_target_i  input  `AddrBus (64)  redirect address, valid with branch_valid_i.
REQ-005 SHALL have port: stall_req_i  input  1  downstream hazard; freeze fetch this cycle.
REQ-006 SHALL have port: icache_req_valid_i  input  1  fetch request outstanding from PC block.
REQ-007 SHALL have port: icache_resp_valid_i  input  1  icache returns instruction this cycle.
REQ-008 SHALL have port: ctrl_signal_o  output  `CTRL_Wire_Bus (2)  PC control code, one of `CTRL_STATE_Default/Branch/Block.
REQ-009 SHALL have port: pc_new_o  output  `AddrBus (64)  redirect target, meaningful only when ctrl_signal_o = Branch.
REQ-010 SHALL have port: flush_o  output  1  one-cycle pulse, coincident with every Branch code, kills younger pipeline stages.
REQ-011 SHALL have port: timeout_o  output  1  sticky error, icache miss exceeded limit.
REQ-012 SHALL have parameter: TIMEOUT, default 255, max cycles in MISS before timeout_o sets (8-bit counter).

Function
REQ-013 SHALL implement FSM states RUN, MISS, HOLD; state, pending-branch flag, pending target, counter registered; outputs combinational from state, registers and inputs.
REQ-014 RUN: miss = icache_req_valid_i & ~icache_resp_valid_i; stall_req_i = 0 and miss = 0 -> ctrl Default (or Branch if branch_valid_i, same cycle, pc_new_o = branch_target_i).
REQ-015 RUN, miss = 1 -> ctrl Block this cycle, next state MISS, counter cleared to 0; miss takes priority over stall_req_i.
REQ-016 RUN, stall_req_i = 1, miss = 0 -> ctrl Block, next state HOLD.
REQ-017 Branch arriving in a Block cycle (any state) SHALL NOT emit Branch; target captured into pending register, pending flag set.
REQ-018 While pending set, further branch_valid_i SHALL be ignored (oldest branch wins).
REQ-019 MISS: ctrl Block each cycle until icache_resp_valid_i = 1; counter increments by 1 per MISS cycle, saturating at 255.
REQ-020 MISS exit on icache_resp_valid_i: -> HOLD if stall_req_i = 1, else -> RUN; ctrl remains Block in exit cycle.
REQ-021 HOLD: ctrl Block while stall_req_i = 1; when stall_req_i = 0 -> RUN, ctrl Block in exit cycle.
REQ-022 First RUN cycle after MISS/HOLD with pending set SHALL emit Branch with pc_new_o = pending target, flush_o = 1, clear pending; a live branch_valid_i that cycle is ignored; this takes priority over a new miss/stall that cycle, which is handled next cycle.
REQ-023 flush_o SHALL equal (ctrl_signal_o == Branch); never asserted with Block.
REQ-024 pc_new_o SHALL be 0 when ctrl_signal_o != Branch.
REQ-025 timeout_o SHALL set when counter reaches TIMEOUT while in MISS and hold until reset; FSM behaviour unchanged by timeout.
REQ-026 icache_resp_valid_i in RUN or HOLD SHALL be ignored.

Reset
REQ-027 rst = 1 SHALL immediately (asynchronously) force state RUN, pending flag 0, pending target 0, counter 0, timeout_o 0.
REQ-028 During rst, ctrl_signal_o SHALL be Default, flush_o 0, pc_new_o 0, independent of inputs.
REQ-029 Reset asserted mid-MISS or with pending branch SHALL discard both; first cycle after release behaves as RUN with empty pending.

Verification
REQ-030 Straight-line: all inputs 0 for 10 cycles after reset -> ctrl Default every cycle, flush_o 0.
REQ-031 Branch in RUN: branch_valid_i = 1, target 0x8000_0100 -> same cycle ctrl Branch, pc_new_o 0x8000_0100, flush_o 1; next cycle Default.
REQ-032 Miss with branch: req=1, resp=0 for 5 cycles, branch target 0x8000_0200 on cycle 2, resp=1 cycle 6 -> Block cycles 1-6, Branch 0x8000_0200 cycle 7, flush_o 1 cycle 7 only.
REQ-033 Two branches while blocked: targets 0x10 then 0x20 during HOLD -> single Branch to 0x10 on exit, no Branch to 0x20.
REQ-034 Timeout: req=1, resp=0 for 300 cycles, TIMEOUT=255 -> timeout_o rises when counter = 255, stays 1; resp=1 then returns to RUN, timeout_o still 1 until rst.
REQ-035 Async reset mid-MISS with pending branch: rst pulse between clock edges -> outputs Default/0 immediately; no Branch emitted after release.
